// File: rtl/ex_issue_stage_pkg.sv
// Shared decode constants for the EX issue stage: opcodes, R-type functs,
// ALU op encodings and the default immediate width.
package ex_issue_stage_pkg;

  localparam int IMM_W_DEF = 16;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/ex_alu_ctrl.sv
// Combinational ALU control: opcode/funct -> ALU op, B-operand select and
// illegal flag. Undecodable instructions become a zeroed ADD.
module ex_alu_ctrl
  import ex_issue_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [2:0]       op_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] imm_sx, imm_zx;

  assign imm_sx = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign imm_zx = {{(WIDTH-IMM_W){1'b0}}, imm_i};

  always_comb begin
    a_o       = rs_i;
    b_o       = rt_i;
    op_o      = ALU_ADD;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OPC_RTYPE: begin
        unique case (funct_i)
          FN_ADD:  op_o = ALU_ADD;
          FN_SUB:  op_o = ALU_SUB;
          FN_AND:  op_o = ALU_AND;
          FN_OR:   op_o = ALU_OR;
          FN_SLT:  op_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW: begin
        op_o = ALU_ADD;
        b_o  = imm_sx;
      end
      OPC_ANDI: begin
        op_o = ALU_AND;
        b_o  = imm_zx;
      end
      OPC_ORI: begin
        op_o = ALU_OR;
        b_o  = imm_zx;
      end
      OPC_BEQ: op_o = ALU_SUB;
      default: illegal_o = 1'b1;
    endcase
    // Illegal entries still flow downstream, but as a harmless 0+0.
    if (illegal_o) begin
      a_o  = '0;
      b_o  = '0;
      op_o = ALU_ADD;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: decodes on accept and holds {a,b,op,illegal} for the ALU
// in a main register M backed by a skid register S; in_ready is registered.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs_val,
  input  logic [WIDTH-1:0] in_rt_val,
  input  logic [IMM_W-1:0] in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic             out_illegal
);

  logic [WIDTH-1:0] dec_a, dec_b;
  logic [2:0]       dec_op;
  logic             dec_ill;

  ex_alu_ctrl #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_ctrl (
    .opcode_i  (in_opcode),
    .funct_i   (in_funct),
    .rs_i      (in_rs_val),
    .rt_i      (in_rt_val),
    .imm_i     (in_imm),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .op_o      (dec_op),
    .illegal_o (dec_ill)
  );

  logic             m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q, rdy_d;
  logic [WIDTH-1:0] m_a_q, m_a_d, m_b_q, m_b_d, s_a_q, s_a_d, s_b_q, s_b_d;
  logic [2:0]       m_op_q, m_op_d, s_op_q, s_op_d;
  logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
  logic             accept, consume;

  assign accept  = in_valid & rdy_q;
  assign consume = m_vld_q & out_ready;

  always_comb begin
    m_vld_d = m_vld_q; m_a_d = m_a_q; m_b_d = m_b_q; m_op_d = m_op_q; m_ill_d = m_ill_q;
    s_vld_d = s_vld_q; s_a_d = s_a_q; s_b_d = s_b_q; s_op_d = s_op_q; s_ill_d = s_ill_q;
    if (flush) begin
      m_vld_d = 1'b0; m_a_d = '0; m_b_d = '0; m_op_d = ALU_AND; m_ill_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || consume) begin
      if (s_vld_q) begin
        // S refills M; an arrival now queues behind it to keep order.
        m_vld_d = 1'b1; m_a_d = s_a_q; m_b_d = s_b_q; m_op_d = s_op_q; m_ill_d = s_ill_q;
        s_vld_d = accept;
        if (accept) begin
          s_a_d = dec_a; s_b_d = dec_b; s_op_d = dec_op; s_ill_d = dec_ill;
        end
      end else begin
        m_vld_d = accept;
        if (accept) begin
          m_a_d = dec_a; m_b_d = dec_b; m_op_d = dec_op; m_ill_d = dec_ill;
        end
      end
    end else if (accept) begin
      s_vld_d = 1'b1; s_a_d = dec_a; s_b_d = dec_b; s_op_d = dec_op; s_ill_d = dec_ill;
    end
    rdy_d = !s_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld_q <= 1'b0; m_a_q <= '0; m_b_q <= '0; m_op_q <= ALU_AND; m_ill_q <= 1'b0;
      s_vld_q <= 1'b0; s_a_q <= '0; s_b_q <= '0; s_op_q <= ALU_AND; s_ill_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      m_vld_q <= m_vld_d; m_a_q <= m_a_d; m_b_q <= m_b_d; m_op_q <= m_op_d; m_ill_q <= m_ill_d;
      s_vld_q <= s_vld_d; s_a_q <= s_a_d; s_b_q <= s_b_d; s_op_q <= s_op_d; s_ill_q <= s_ill_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = m_vld_q;
  assign out_a       = m_a_q;
  assign out_b       = m_b_q;
  assign out_op      = m_op_q;
  assign out_illegal = m_ill_q;

endmodule
